// File: rtl/tick_sched_pkg.sv
// Shared types and default constants for the tick scheduler and its channels.
package tick_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_t;

    localparam int CLK_PER_US_100MHZ = 100;
    localparam int PERIOD_W_DEFAULT  = 24;

endpackage

// File: rtl/tick_sched_channel.sv
// One tick channel: counts microsecond pulses and emits a tick pulse and a
// toggle level every programmed period, optionally stopping after one tick.
module tick_sched_channel
    import tick_sched_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                us_tick,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    input  logic                enable,
    input  logic                oneshot,
    output logic                tick,
    output logic                toggle,
    output logic                busy
);

    logic [PERIOD_W-1:0] count_q, count_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                oneshot_q, oneshot_d;
    logic                busy_q, busy_d;
    logic                tick_q, tick_d;
    logic                toggle_q, toggle_d;
    logic                at_wrap;

    // A load takes priority over a coincident wrap, so a rewrite suppresses
    // the tick that would otherwise have fired on the same edge.
    always_comb begin
        count_d   = count_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        busy_d    = busy_q;
        tick_d    = 1'b0;
        toggle_d  = toggle_q;
        at_wrap   = (count_q == (period_q - PERIOD_W'(1)));
        if (load) begin
            period_d  = period;
            oneshot_d = oneshot;
            count_d   = '0;
            busy_d    = enable && (period != '0);
        end else if (busy_q && us_tick) begin
            if (at_wrap) begin
                count_d  = '0;
                tick_d   = 1'b1;
                toggle_d = ~toggle_q;
                if (oneshot_q) begin
                    busy_d = 1'b0;
                end
            end else begin
                count_d = count_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            toggle_q  <= toggle_d;
        end
    end

    assign tick   = tick_q;
    assign toggle = toggle_q;
    assign busy   = busy_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared microsecond timebase feeding a bank of programmable tick channels,
// configured through a two-state valid/ready write port.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CLK_PER_US = CLK_PER_US_100MHZ,
    parameter int CHANNELS   = 4,
    parameter int PERIOD_W   = PERIOD_W_DEFAULT,
    parameter int CH_W       = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_enable,
    input  logic                cfg_oneshot,
    output logic                us_tick,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] toggle,
    output logic [CHANNELS-1:0] busy
);

    localparam int                PRESC_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_US - 1);

    cfg_state_t          state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                us_tick_q, us_tick_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                enable_q, enable_d;
    logic                oneshot_q, oneshot_d;
    logic                apply;
    logic [CHANNELS-1:0] load;

    // Free-running prescaler; config traffic never disturbs it.
    always_comb begin
        presc_d   = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        us_tick_d = (presc_q == PRESC_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            us_tick_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            us_tick_q <= us_tick_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_valid) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == IDLE);
        apply     = (state_q == APPLY);
    end

    // Write fields are captured at the handshake so the host may change them
    // while the APPLY cycle is in progress.
    always_comb begin
        chan_d    = chan_q;
        period_d  = period_q;
        enable_d  = enable_q;
        oneshot_d = oneshot_q;
        if (cfg_valid && cfg_ready) begin
            chan_d    = cfg_chan;
            period_d  = cfg_period;
            enable_d  = cfg_enable;
            oneshot_d = cfg_oneshot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q    <= '0;
            period_q  <= '0;
            enable_q  <= 1'b0;
            oneshot_q <= 1'b0;
        end else begin
            chan_q    <= chan_d;
            period_q  <= period_d;
            enable_q  <= enable_d;
            oneshot_q <= oneshot_d;
        end
    end

    assign us_tick = us_tick_q;

    // Indices at or above CHANNELS match no load strobe and are dropped.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign load[g] = apply && (chan_q == CH_W'(g));

        tick_sched_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .us_tick (us_tick_q),
            .load    (load[g]),
            .period  (period_q),
            .enable  (enable_q),
            .oneshot (oneshot_q),
            .tick    (tick[g]),
            .toggle  (toggle[g]),
            .busy    (busy[g])
        );
    end

endmodule
